// File: rtl/pll_timebase_counter.sv
// PLL lock qualification, 1 Hz / scan-rate tick generation and an mm:ss BCD stopwatch.
// Define TIMEBASE_FAST_SIM_EN to shrink the dividers and settle time for fast simulation.
module pll_timebase_counter #(
  parameter int SEC_DIV       = 16777408,
  parameter int SCAN_DIV      = 16384,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       run,
  input  logic       clr,
  output logic       ready,
  output logic       tick_sec,
  output logic       tick_scan,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       wrap
);

`ifdef TIMEBASE_FAST_SIM_EN
  localparam int SEC_N    = 16;
  localparam int SCAN_N   = 4;
  localparam int SETTLE_N = 4;
`else
  localparam int SEC_N    = SEC_DIV;
  localparam int SCAN_N   = SCAN_DIV;
  localparam int SETTLE_N = SETTLE_CYCLES;
`endif

  localparam int SEC_W  = $clog2(SEC_N);
  localparam int SCAN_W = $clog2(SCAN_N);
  localparam int SET_W  = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;

  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_N - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_N - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_N - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [SET_W-1:0]   settle_cnt, settle_next;
  logic               lock_m, lock_s;
  logic [SEC_W-1:0]   sec_cnt;
  logic [SCAN_W-1:0]  scan_cnt;
  logic               sec_wrap, scan_wrap, stay_run;
  logic [3:0]         so_n, st_n, mo_n, mt_n;
  logic               roll;

  // pll_locked comes from another clock domain; only lock_s is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    case (state)
      WAIT_LOCK: begin
        settle_next = '0;
        if (lock_s) state_next = SETTLE;
      end
      SETTLE: begin
        if (!lock_s) begin
          state_next  = WAIT_LOCK;
          settle_next = '0;
        end else if (settle_cnt == SET_LAST) begin
          state_next  = RUN;
          settle_next = '0;
        end else begin
          settle_next = settle_cnt + 1'b1;
        end
      end
      RUN: begin
        settle_next = '0;
        if (!lock_s) state_next = WAIT_LOCK;
      end
      default: begin
        state_next  = WAIT_LOCK;
        settle_next = '0;
      end
    endcase
  end

  // ready is registered from the next state so it is high exactly while state == RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      ready      <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      ready      <= (state_next == RUN);
    end
  end

  // A wrap in the last RUN cycle still ticks; counters restart from 0 on every RUN entry.
  assign sec_wrap  = (state == RUN) && (sec_cnt == SEC_LAST);
  assign scan_wrap = (state == RUN) && (scan_cnt == SCAN_LAST);
  assign stay_run  = (state == RUN) && (state_next == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt   <= '0;
      scan_cnt  <= '0;
      tick_sec  <= 1'b0;
      tick_scan <= 1'b0;
    end else begin
      sec_cnt   <= (stay_run && !sec_wrap) ? sec_cnt + 1'b1 : '0;
      scan_cnt  <= (stay_run && !scan_wrap) ? scan_cnt + 1'b1 : '0;
      tick_sec  <= sec_wrap;
      tick_scan <= scan_wrap;
    end
  end

  always_comb begin
    so_n = sec_ones + 4'd1;
    st_n = sec_tens;
    mo_n = min_ones;
    mt_n = min_tens;
    roll = 1'b0;
    if (sec_ones >= 4'd9) begin
      so_n = 4'd0;
      st_n = sec_tens + 4'd1;
      if (sec_tens >= 4'd5) begin
        st_n = 4'd0;
        mo_n = min_ones + 4'd1;
        if (min_ones >= 4'd9) begin
          mo_n = 4'd0;
          mt_n = min_tens + 4'd1;
          if (min_tens >= 4'd5) begin
            mt_n = 4'd0;
            roll = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
      wrap     <= 1'b0;
    end else if (clr) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
      wrap     <= 1'b0;
    end else if (sec_wrap && run) begin
      sec_ones <= so_n;
      sec_tens <= st_n;
      min_ones <= mo_n;
      min_tens <= mt_n;
      wrap     <= roll;
    end else begin
      wrap     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pll_timebase_counter.sv
// Bench for pll_timebase_counter: a lock-history / elapsed-seconds reference model checked every cycle,
// plus directed checks for lock latency, first tick, clear-vs-tick, hold, lock loss, rollover and async reset.
module tb_pll_timebase_counter;

`ifdef TIMEBASE_FAST_SIM_EN
  localparam int SD = 16;
  localparam int SC = 4;
  localparam int ST = 4;
`else
  localparam int SD = 10;
  localparam int SC = 4;
  localparam int ST = 8;
`endif

  logic       clk, rst, pll_locked, run, clr;
  logic       ready, tick_sec, tick_scan, wrap;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;

  pll_timebase_counter #(
    .SEC_DIV(10),
    .SCAN_DIV(4),
    .SETTLE_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
    .run(run),
    .clr(clr),
    .ready(ready),
    .tick_sec(tick_sec),
    .tick_scan(tick_scan),
    .sec_ones(sec_ones),
    .sec_tens(sec_tens),
    .min_ones(min_ones),
    .min_tens(min_tens),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: lock samples seen, elapsed stopwatch seconds, cycles spent in RUN.
  bit l_q[$];
  int m_secs;
  bit m_ready, m_tick_sec, m_tick_scan, m_wrap;
  int m_idx;

  function automatic logic [15:0] enc(int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // RUN holds iff the lock sample two edges back and the ST before it were all high.
  function automatic bit lock_ok();
    int n;
    n = l_q.size();
    if (n < ST + 3) return 1'b0;
    for (int i = n - 3 - ST; i <= n - 3; i++)
      if (!l_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit tick_due();
    return m_ready && (m_idx % SD == SD - 1);
  endfunction

  task automatic model_edge();
    bit ts, tc, nr;
    if (rst) begin
      l_q.delete();
      m_secs = 0; m_ready = 0; m_idx = 0;
      m_tick_sec = 0; m_tick_scan = 0; m_wrap = 0;
    end else begin
      ts = tick_due();
      tc = m_ready && (m_idx % SC == SC - 1);
      if (clr) begin
        m_secs = 0;
        m_wrap = 0;
      end else if (ts && run) begin
        m_wrap = (m_secs == 3599);
        m_secs = (m_secs + 1) % 3600;
      end else begin
        m_wrap = 0;
      end
      l_q.push_back(pll_locked);
      if (l_q.size() > ST + 3) void'(l_q.pop_front());
      nr = lock_ok();
      m_idx = nr ? (m_ready ? m_idx + 1 : 0) : 0;
      m_ready = nr;
      m_tick_sec = ts;
      m_tick_scan = tc;
    end
  endtask

  function automatic logic [15:0] dig();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("ready", {15'd0, ready}, {15'd0, m_ready});
    check("tick_sec", {15'd0, tick_sec}, {15'd0, m_tick_sec});
    check("tick_scan", {15'd0, tick_scan}, {15'd0, m_tick_scan});
    check("wrap", {15'd0, wrap}, {15'd0, m_wrap});
    check("digits", dig(), enc(m_secs));
  endtask

  task automatic wait_ready(string tag);
    int t;
    t = 0;
    while (!m_ready && t < 200) begin
      cyc();
      t++;
    end
    check(tag, {15'd0, ready}, 16'd1);
  endtask

  task automatic run_until_secs(string tag, int target, int limit);
    int t;
    t = 0;
    while (m_secs != target && t < limit) begin
      cyc();
      t++;
    end
    check(tag, dig(), enc(target));
  endtask

  initial begin
    int t;
    rst = 1'b1; pll_locked = 1'b0; run = 1'b0; clr = 1'b0;
    repeat (3) cyc();
    check("reset_digits", dig(), 16'h0000);
    rst = 1'b0;

    // Lock qualification: 2 sync stages + 1 WAIT_LOCK edge + ST settle edges.
    pll_locked = 1'b1;
    t = 0;
    while (!ready && t < 60) begin
      cyc();
      t++;
    end
    check("lock_latency", 16'(t), 16'(ST + 3));

    // One-cycle glitch during SETTLE restarts qualification.
    pll_locked = 1'b0;
    repeat (6) cyc();
    pll_locked = 1'b1;
    repeat (5) cyc();
    pll_locked = 1'b0;
    cyc();
    pll_locked = 1'b1;
    t = 0;
    while (!ready && t < 60) begin
      cyc();
      t++;
    end
    check("relock_latency", 16'(t), 16'(ST + 3));

    // First tick_sec arrives SD cycles after ready rises.
    run = 1'b1;
    t = 0;
    while (!tick_sec && t < 4 * SD) begin
      cyc();
      t++;
    end
    check("first_tick", 16'(t), 16'(SD));
    t = 0;
    do begin
      cyc();
      t++;
    end while (!tick_sec && t < 4 * SD);
    check("tick_period", 16'(t), 16'(SD));

    // Randomized run/clr/lock activity.
    for (int i = 0; i < 400; i++) begin
      run        = ($urandom_range(0, 7) != 0);
      clr        = ($urandom_range(0, 60) == 0);
      pll_locked = ($urandom_range(0, 150) != 0);
      cyc();
    end
    clr = 1'b0; pll_locked = 1'b1; run = 1'b1;
    wait_ready("ready_after_random");

    // Clear coincident with the tick that would make 00:10.
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    t = 0;
    while (!(m_secs == 9 && tick_due()) && t < 20 * SD) begin
      cyc();
      t++;
    end
    check("at_0009", dig(), 16'h0009);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("clr_tick_digits", dig(), 16'h0000);
    check("clr_tick_pulse", {15'd0, tick_sec}, 16'd1);

    // run = 0 across 5 seconds holds the count.
    run_until_secs("reach_0007", 7, 20 * SD);
    run = 1'b0;
    repeat (5 * SD) cyc();
    check("hold_digits", dig(), 16'h0007);

    // Lock loss at 01:23, then relock and resume.
    run = 1'b1;
    run_until_secs("reach_0123", 83, 100 * SD);
    pll_locked = 1'b0;
    repeat (3 * SD) cyc();
    check("lost_ready", {15'd0, ready}, 16'd0);
    check("lost_digits", dig(), 16'h0123);
    pll_locked = 1'b1;
    wait_ready("relock_ready");
    run_until_secs("resume_0124", 84, 3 * SD);

    // Rollover 59:59 -> 00:00.
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    run_until_secs("reach_5959", 3599, 3600 * SD + 50);
    t = 0;
    while (!m_wrap && t < 3 * SD) begin
      cyc();
      t++;
    end
    check("wrap_pulse", {15'd0, wrap}, 16'd1);
    check("wrap_digits", dig(), 16'h0000);
    cyc();
    check("wrap_one_cycle", {15'd0, wrap}, 16'd0);

    // Asynchronous reset mid-count.
    repeat (3 * SD + 3) cyc();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_ready", {15'd0, ready}, 16'd0);
    check("async_digits", dig(), 16'h0000);
    check("async_ticks", {14'd0, tick_sec, tick_scan}, 16'd0);
    check("async_wrap", {15'd0, wrap}, 16'd0);
    cyc();
    rst = 1'b0;
    wait_ready("ready_after_rst");
    repeat (3 * SD) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_timebase_counter.md
Name: pll_timebase_counter

Overview:
- Consumes the PLL output clock (16.777408 MHz) and its `locked` flag.
- Qualifies lock, then derives a 1 Hz tick and a display-scan tick.
- Runs an mm:ss BCD stopwatch counter.
- Feeds the seven-segment display driver: four BCD digits and the scan strobe.

Parameters:
- SEC_DIV, 16777408: clk cycles per 1 Hz tick; must be >= 2.
- SCAN_DIV, 16384: clk cycles per scan tick (~1024 Hz); must be >= 2.
- SETTLE_CYCLES, 1024: consecutive synchronized-locked cycles required before RUN; must be >= 1.

Ports:
- clk  in  1  PLL output clock (outclk_0 of the PLL).
- rst  in  1  asynchronous reset, active-high.
- pll_locked  in  1  PLL lock flag; asynchronous to clk, so it is synchronized internally.
- run  in  1  level; 1 = stopwatch counts, 0 = holds.
- clr  in  1  synchronous clear of the BCD digits.
- ready  out  1  1 while in RUN state.
- tick_sec  out  1  one-cycle pulse at 1 Hz.
- tick_scan  out  1  one-cycle pulse per SCAN_DIV.
- sec_ones  out  4  BCD, 0-9.
- sec_tens  out  4  BCD, 0-5.
- min_ones  out  4  BCD, 0-9.
- min_tens  out  4  BCD, 0-5.
- wrap  out  1  one-cycle pulse when the count rolls 59:59 -> 00:00.

Behaviour:
- Reset: all outputs, digits, prescalers, synchronizer flops and the settle counter are 0; FSM is in WAIT_LOCK.
- pll_locked passes through a 2-flop synchronizer; lock_s is the second flop.
- FSM:
  - WAIT_LOCK: settle counter = 0. Goes to SETTLE when lock_s = 1.
  - SETTLE: settle counter increments each cycle. lock_s = 0 returns to WAIT_LOCK and clears the counter. Goes to RUN on the cycle the counter equals SETTLE_CYCLES-1.
  - RUN: ready = 1. lock_s = 0 returns to WAIT_LOCK on the next edge.
- ready is registered and equals (state == RUN).
- Prescalers (sec_cnt, scan_cnt), width $clog2(DIV):
  - Held at 0 outside RUN; entering RUN, both are 0 on the first RUN cycle.
  - In RUN each counts 0..DIV-1, then wraps to 0.
  - tick_sec is registered: high for exactly one cycle, in the cycle after sec_cnt == SEC_DIV-1. First pulse comes SEC_DIV cycles after RUN entry; period is exactly SEC_DIV.
  - tick_scan follows the same rule with SCAN_DIV.
  - On leaving RUN, both ticks are 0 from the next cycle and the prescalers reset to 0.
- BCD counter, updated on the same edge that sets tick_sec:
  - Priority: clr, then increment.
  - clr = 1: all digits <= 0, wrap <= 0, regardless of state, tick or run.
  - Increment when prescaler wrap && run && RUN.
  - Increment rules:
    - sec_ones 9 -> 0 carries to sec_tens.
    - sec_tens 5 -> 0 carries to min_ones.
    - min_ones 9 -> 0 carries to min_tens.
    - min_tens 5 -> 0 completes the roll, so 59:59 -> 00:00 and wrap pulses high for one cycle.
  - run = 0 or state != RUN: digits hold.
  - Digits are retained across lock loss; only rst or clr zero them.
- Simultaneous events:
  - clr with a tick: clear wins and tick_sec still pulses.
  - run toggling mid-second does not reset the prescaler.
  - Lock loss on the same cycle as a prescaler wrap: that tick and increment still occur. All later ones are suppressed.
- Reset mid-operation: immediate asynchronous return to the reset values above.
- Digits never take values outside the ranges listed under Ports.

Optional Feature:
- Macro: TIMEBASE_FAST_SIM_EN.
- Defined: effective SEC_DIV = 16, SCAN_DIV = 4 and SETTLE_CYCLES = 4 override the parameters, for fast simulation; all other behaviour is identical.
- Undefined: the parameters apply as given.
- Synthesis builds must not define the macro.

Test Plan:
- Lock qualification (SETTLE_CYCLES=8): rst deasserted, pll_locked=1 steady -> ready rises 2 (sync) + 8 cycles later, +/-1 for the registered output. Digits stay 00:00.
- Lock glitch: pll_locked drops for 1 cycle during SETTLE -> FSM returns to WAIT_LOCK and ready rises 8 cycles after lock_s is stable again.
- Tick timing (SEC_DIV=10, SCAN_DIV=4) in RUN -> tick_sec pulses every 10 cycles and tick_scan every 4, each 1 cycle wide. First tick_sec is 10 cycles after ready rises.
- Rollover: preload via 3599 ticks with run=1 -> digits 5,9,5,9. The next tick gives 0,0,0,0 with wrap=1 for one cycle.
- clr coincident with tick_sec at 00:09 -> digits 00:00, not 00:10. With run=0 across 5 ticks, digits are unchanged.
- Lock loss in RUN at 01:23 -> ready falls, ticks stop and digits hold 01:23. Relock + settle resumes counting from 01:23. Asynchronous rst mid-count -> all outputs 0 immediately.
